// File: rtl/key_cmd_pkg.sv
// Shared definitions for the key command sequencer: FSM state encoding,
// opcode values and a constant-evaluable ceiling log2.
package key_cmd_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ISSUE = 4'b0010,
        S_CLEAR = 4'b0100,
        S_WAIT  = 4'b1000
    } state_t;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/key_cmd_fifo.sv
// Synchronous FIFO with flush; pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate counter.
module key_cmd_fifo
    import key_cmd_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [AW:0]      o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (o_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_pop  = i_pop && !o_empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/key_command_sequencer.sv
// Queues one-hot operation keys and a clear key, and issues them one at a time
// to the compute engine over the CLEAR/COMPUTE/DONE handshake with a DONE watchdog.
module key_command_sequencer
    import key_cmd_pkg::*;
#(
    parameter int NUM_OPS        = 2,
    parameter int OP_W           = 1,
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int CW = clog2(QUEUE_DEPTH) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_key_clear,
    input  logic [NUM_OPS-1:0] i_key_op,
    input  logic               i_cmd_done,
    output logic               o_cmd_clear,
    output logic               o_cmd_compute,
    output logic [OP_W-1:0]    o_cmd_operation,
    output logic               o_busy,
    output logic [CW-1:0]      o_queue_count,
    output logic               o_key_dropped,
    output logic               o_key_invalid,
    output logic               o_cmd_timeout
);

    localparam int TW_RAW = clog2(TIMEOUT_CYCLES);
    localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;

    state_t          r_state;
    logic            r_clear_pending;
    logic [TW-1:0]   r_timer;
    logic            r_cmd_clear;
    logic            r_cmd_compute;
    logic [OP_W-1:0] r_cmd_operation;
    logic            r_busy;
    logic            r_key_dropped;
    logic            r_key_invalid;
    logic            r_cmd_timeout;

    logic [OP_W-1:0] w_op_idx;
    logic [OP_W-1:0] w_head;
    logic            w_op_onehot;
    logic            w_op_any;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;

    always_comb begin
        w_op_idx = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (i_key_op[i]) w_op_idx = OP_W'(i);
        end
    end

    assign w_op_onehot = $onehot(i_key_op);
    assign w_op_any    = |i_key_op;
    // A clear in the same cycle swallows any operation key silently.
    assign w_push      = !i_key_clear && w_op_onehot;
    assign w_pop       = (r_state == S_IDLE) && !r_clear_pending && !w_empty;

    key_cmd_fifo #(
        .WIDTH (OP_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_key_clear),
        .i_push      (w_push),
        .i_push_data (w_op_idx),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (o_queue_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_key_dropped <= 1'b0;
            r_key_invalid <= 1'b0;
        end else begin
            r_key_dropped <= w_push && w_full && !w_pop;
            r_key_invalid <= !i_key_clear && w_op_any && !w_op_onehot;
        end
    end

    // NOTE: every output is assigned next-state values here, so BUSY tracks the state it enters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_clear_pending <= 1'b0;
            r_timer         <= '0;
            r_cmd_clear     <= 1'b0;
            r_cmd_compute   <= 1'b0;
            r_cmd_operation <= '0;
            r_busy          <= 1'b0;
            r_cmd_timeout   <= 1'b0;
        end else begin
            r_cmd_clear   <= 1'b0;
            r_cmd_compute <= 1'b0;
            r_cmd_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_clear_pending) begin
                        r_state         <= S_CLEAR;
                        r_cmd_clear     <= 1'b1;
                        r_clear_pending <= 1'b0;
                        r_busy          <= 1'b1;
                    end else if (!w_empty) begin
                        r_state         <= S_ISSUE;
                        r_cmd_compute   <= 1'b1;
                        r_cmd_operation <= w_head;
                        r_busy          <= 1'b1;
                    end
                end
                S_ISSUE, S_CLEAR: begin
                    r_state <= S_WAIT;
                    r_timer <= '0;
                    r_busy  <= 1'b1;
                end
                S_WAIT: begin
                    if (i_cmd_done) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (TIMEOUT_CYCLES != 0 && r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_state       <= S_IDLE;
                        r_busy        <= 1'b0;
                        r_cmd_timeout <= 1'b1;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            // A new clear key outranks the one just consumed, so it is applied last.
            if (i_key_clear) r_clear_pending <= 1'b1;
        end
    end

    assign o_cmd_clear     = r_cmd_clear;
    assign o_cmd_compute   = r_cmd_compute;
    assign o_cmd_operation = r_cmd_operation;
    assign o_busy          = r_busy;
    assign o_key_dropped   = r_key_dropped;
    assign o_key_invalid   = r_key_invalid;
    assign o_cmd_timeout   = r_cmd_timeout;

endmodule
